rvv_backend_vrf_bank: RTL and testbench

Parametrised vector register file storage for the RVV backend and the next generation of the per-byte-enabled VRF register array. It adds NUM_WP byte-enabled write ports with fixed port priority, NUM_RP registered read ports with selectable write-to-read bypass, and a hardware clear sequencer that zeroes the file one register per cycle. It sits between the retire/writeback stage (write side) and the operand-read stage (read side).

---
 rtl/rvv_backend_vrf_bank.sv | 147 ++++++++++++++
 tb/tb_rvv_backend_vrf_bank.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_vrf_bank.sv
// rtl/rvv_backend_vrf_bank.sv - byte-enabled multi-port vector register file bank with bypass reads and clear sequencer
module rvv_backend_vrf_bank #(
  parameter int NUM_VRF = 32,
  parameter int VLEN    = 128,
  parameter int NUM_WP  = 2,
  parameter int NUM_RP  = 4,
  parameter int BYPASS  = 1,
  parameter int ADDR_W  = $clog2(NUM_VRF),
  localparam int VLENB  = VLEN / 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WP-1:0]                 wr_valid,
  input  logic [NUM_WP-1:0][ADDR_W-1:0]     wr_addr,
  input  logic [NUM_WP-1:0][VLENB-1:0]      wr_be,
  input  logic [NUM_WP-1:0][VLEN-1:0]       wr_data,
  output logic                              wr_ready,
  input  logic [NUM_RP-1:0]                 rd_en,
  input  logic [NUM_RP-1:0][ADDR_W-1:0]     rd_addr,
  output logic [NUM_RP-1:0]                 rd_valid,
  output logic [NUM_RP-1:0][VLEN-1:0]       rd_data,
  input  logic                              clr_req,
  output logic                              clr_busy,
  output logic                              clr_done
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VRF - 1);

  logic [NUM_VRF-1:0][VLEN-1:0] mem;
  logic [NUM_RP-1:0][VLEN-1:0]  rd_word;
  logic [NUM_WP-1:0]            wr_fire;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_VRF;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    clr_busy = (state_q == CLEAR);
    clr_done = done_q;
  end

  assign wr_ready = !clr_busy;

  always_comb begin
    for (int p = 0; p < NUM_WP; p++) begin
      wr_fire[p] = wr_valid[p] && wr_ready && addr_ok(wr_addr[p]);
    end
  end

  // Clear and writes never share a cycle because wr_ready is low while clearing.
  // Later ports are assigned last, so the highest index wins on byte conflicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      if (state_q == CLEAR) mem[cnt_q] <= '0;
      for (int p = 0; p < NUM_WP; p++) begin
        if (wr_fire[p]) begin
          for (int b = 0; b < VLENB; b++) begin
            if (wr_be[p][b]) mem[wr_addr[p]][b*8 +: 8] <= wr_data[p][b*8 +: 8];
          end
        end
      end
    end
  end

  // Read word: storage value, optionally overlaid with this cycle's clear and writes
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_RP; r++) begin
      if (addr_ok(rd_addr[r])) begin
        rd_word[r] = mem[rd_addr[r]];
        if (BYPASS != 0) begin
          if ((state_q == CLEAR) && (cnt_q == rd_addr[r])) rd_word[r] = '0;
          for (int p = 0; p < NUM_WP; p++) begin
            if (wr_fire[p] && (wr_addr[p] == rd_addr[r])) begin
              for (int b = 0; b < VLENB; b++) begin
                if (wr_be[p][b]) rd_word[r][b*8 +: 8] = wr_data[p][b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int r = 0; r < NUM_RP; r++) begin
        if (rd_en[r]) rd_data[r] <= rd_word[r];
      end
    end
  end

`ifdef ASSERT_ON
  a_no_x: assert property (@(posedge clk) disable iff (rst) !$isunknown(mem));
  a_busy_done: assert property (@(posedge clk) disable iff (rst) !(clr_busy && clr_done));
`endif

endmodule

// File: tb/tb_rvv_backend_vrf_bank.sv
// tb/tb_rvv_backend_vrf_bank.sv - bench for rvv_backend_vrf_bank across bypass, read-first and 24-entry builds
module tb_rvv_backend_vrf_bank;

  localparam int NI = 3;
  localparam int NV [NI] = '{32, 32, 24};
  localparam int BYP[NI] = '{1, 0, 1};

  logic clk = 1'b0;
  logic rst;
  logic [1:0]        wr_valid;
  logic [1:0][4:0]   wr_addr;
  logic [1:0][15:0]  wr_be;
  logic [1:0][127:0] wr_data;
  logic [3:0]        rd_en;
  logic [3:0][4:0]   rd_addr;
  logic              clr_req;

  logic              wrdy  [NI];
  logic              cbusy [NI];
  logic              cdone [NI];
  logic [3:0]        rv    [NI];
  logic [3:0][127:0] rdat  [NI];

  always #5 clk = ~clk;

  rvv_backend_vrf_bank #(.NUM_VRF(32), .VLEN(128), .NUM_WP(2), .NUM_RP(4), .BYPASS(1)) dut_wf (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_ready(wrdy[0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[0]), .rd_data(rdat[0]),
    .clr_req(clr_req), .clr_busy(cbusy[0]), .clr_done(cdone[0]));

  rvv_backend_vrf_bank #(.NUM_VRF(32), .VLEN(128), .NUM_WP(2), .NUM_RP(4), .BYPASS(0)) dut_rf (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_ready(wrdy[1]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[1]), .rd_data(rdat[1]),
    .clr_req(clr_req), .clr_busy(cbusy[1]), .clr_done(cdone[1]));

  rvv_backend_vrf_bank #(.NUM_VRF(24), .VLEN(128), .NUM_WP(2), .NUM_RP(4), .BYPASS(1)) dut_24 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_ready(wrdy[2]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[2]), .rd_data(rdat[2]),
    .clr_req(clr_req), .clr_busy(cbusy[2]), .clr_done(cdone[2]));

  // Reference model: byte arrays plus a "clear cycles remaining" count per instance
  logic [127:0]      mm [NI][32];
  int                cl [NI];
  bit                dn [NI];
  logic [3:0]        ev [NI];
  logic [3:0][127:0] ed [NI];

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] fillv [32];

  typedef struct {
    logic [1:0]   wv;
    logic [4:0]   wa0, wa1;
    logic [15:0]  be0, be1;
    logic [127:0] d0, d1;
    logic [4:0]   ra;
    logic [127:0] e_wf, e_rf, e_24;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 32; a++) mm[k][a] = '0;
      cl[k] = 0;
      dn[k] = 1'b0;
      ev[k] = '0;
      ed[k] = '0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("wr_ready[%0d]", k), 128'(wrdy[k]), 128'(cl[k] == 0));
      chk($sformatf("clr_busy[%0d]", k), 128'(cbusy[k]), 128'(cl[k] > 0));
      chk($sformatf("clr_done[%0d]", k), 128'(cdone[k]), 128'(dn[k]));
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("rd_valid[%0d][%0d]", k, r), 128'(rv[k][r]), 128'(ev[k][r]));
        chk($sformatf("rd_data[%0d][%0d]", k, r), rdat[k][r], ed[k][r]);
      end
    end
  endtask

  task automatic step();
    logic [127:0] nm [32];
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 32; a++) nm[a] = mm[k][a];
      if (cl[k] > 0) begin
        nm[NV[k] - cl[k]] = '0;
        cl[k]--;
        dn[k] = (cl[k] == 0);
      end else begin
        dn[k] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          if (wr_valid[p] && int'(wr_addr[p]) < NV[k]) begin
            for (int b = 0; b < 16; b++) begin
              if (wr_be[p][b]) nm[wr_addr[p]][b*8 +: 8] = wr_data[p][b*8 +: 8];
            end
          end
        end
        if (clr_req) cl[k] = NV[k];
      end
      for (int r = 0; r < 4; r++) begin
        ev[k][r] = rd_en[r];
        if (rd_en[r]) begin
          if (int'(rd_addr[r]) >= NV[k]) ed[k][r] = '0;
          else if (BYP[k] != 0)          ed[k][r] = nm[rd_addr[r]];
          else                           ed[k][r] = mm[k][rd_addr[r]];
        end
      end
      for (int a = 0; a < 32; a++) mm[k][a] = nm[a];
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    wr_valid = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; clr_req = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic fill_all();
    idle_inputs();
    for (int a = 0; a < 32; a += 2) begin
      fillv[a]     = rnd128() | {16{8'h01}};
      fillv[a + 1] = rnd128() | {16{8'h01}};
      wr_valid = 2'b11;
      wr_addr[0] = 5'(a);     wr_addr[1] = 5'(a + 1);
      wr_be = {16'hFFFF, 16'hFFFF};
      wr_data[0] = fillv[a];  wr_data[1] = fillv[a + 1];
      step();
    end
    idle_inputs();
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      rd_en = 4'hF;
      for (int r = 0; r < 4; r++) rd_addr[r] = 5'(4 * i + r);
      step();
    end
    rd_en = '0;
  endtask

  initial begin
    vec_t tbl [6];
    logic [127:0] va, v5, vm, ve, vg, vh;
    int bcnt, b24, dcnt, d24, guard;

    va = {16{8'hAA}}; v5 = {16{8'h55}}; ve = {16{8'h11}}; vg = {16{8'h77}};
    vm = 128'h00000000_55555555_AAAAAAAA_55555555;
    tbl[0] = '{2'b11, 5'd3,  5'd3, 16'h00FF, 16'h0F0F, va, v5, 5'd3,  vm, '0, vm};
    tbl[1] = '{2'b00, 5'd0,  5'd0, 16'h0000, 16'h0000, '0, '0, 5'd3,  vm, vm, vm};
    tbl[2] = '{2'b01, 5'd5,  5'd0, 16'hFFFF, 16'h0000, ve, '0, 5'd5,  ve, '0, ve};
    tbl[3] = '{2'b00, 5'd0,  5'd0, 16'h0000, 16'h0000, '0, '0, 5'd5,  ve, ve, ve};
    tbl[4] = '{2'b01, 5'd30, 5'd0, 16'hFFFF, 16'h0000, vg, '0, 5'd30, vg, '0, '0};
    tbl[5] = '{2'b00, 5'd0,  5'd0, 16'h0000, 16'h0000, '0, '0, 5'd30, vg, vg, '0};

    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Every register reads zero after reset
    read_all();

    // Directed vectors: port merge/priority, bypass vs read-first, out-of-range address
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      wr_valid = tbl[i].wv;
      wr_addr[0] = tbl[i].wa0; wr_addr[1] = tbl[i].wa1;
      wr_be[0] = tbl[i].be0;   wr_be[1] = tbl[i].be1;
      wr_data[0] = tbl[i].d0;  wr_data[1] = tbl[i].d1;
      rd_en = 4'b0001;
      rd_addr[0] = tbl[i].ra;
      step();
      chk($sformatf("vec%0d wf", i), rdat[0][0], tbl[i].e_wf);
      chk($sformatf("vec%0d rf", i), rdat[1][0], tbl[i].e_rf);
      chk($sformatf("vec%0d n24", i), rdat[2][0], tbl[i].e_24);
    end
    idle_inputs();

    // Full clear with a write to v7 held until accepted
    fill_all();
    vh = rnd128() | {16{8'h01}};
    wr_valid = 2'b01; wr_addr[0] = 5'd7; wr_be[0] = 16'hFFFF; wr_data[0] = vh;
    clr_req = 1'b1;
    bcnt = 0; b24 = 0; dcnt = 0; d24 = 0;
    for (int i = 0; i < 36; i++) begin
      step();
      clr_req = 1'b0;
      if (cbusy[0]) bcnt++;
      if (cbusy[2]) b24++;
      if (cdone[0]) dcnt++;
      if (cdone[2]) d24++;
    end
    chk("clear busy cycles", 128'(bcnt), 128'd32);
    chk("clear busy cycles n24", 128'(b24), 128'd24);
    chk("clear done pulses", 128'(dcnt), 128'd1);
    chk("clear done pulses n24", 128'(d24), 128'd1);
    idle_inputs();
    read_all();
    rd_en = 4'b0011; rd_addr[0] = 5'd7; rd_addr[1] = 5'd0;
    step();
    chk("held write v7", rdat[0][0], vh);
    chk("cleared v0", rdat[0][1], 128'd0);
    idle_inputs();

    // Reads during a clear, then reset in the middle of it
    fill_all();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    guard = 0;
    while (cl[0] != 22 && guard < 40) begin step(); guard++; end
    chk("reach cnt10", 128'(cl[0]), 128'd22);
    rd_en = 4'b0011; rd_addr[0] = 5'd4; rd_addr[1] = 5'd20;
    step();
    chk("midclear v4", rdat[0][0], 128'd0);
    chk("midclear v20", rdat[0][1], fillv[20]);
    rd_en = '0;
    guard = 0;
    while (cl[0] != 17 && guard < 40) begin step(); guard++; end
    chk("reach cnt15", 128'(cl[0]), 128'd17);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst busy[%0d]", k), 128'(cbusy[k]), 128'd0);
      chk($sformatf("rst done[%0d]", k), 128'(cdone[k]), 128'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    read_all();
    read_all();

    // Randomised traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        wr_valid[p] = 1'($urandom_range(1));
        wr_addr[p] = ($urandom_range(1) != 0) ? 5'($urandom_range(3)) : 5'($urandom_range(31));
        wr_be[p] = 16'($urandom);
        wr_data[p] = rnd128();
      end
      for (int r = 0; r < 4; r++) begin
        rd_en[r] = 1'($urandom_range(1));
        rd_addr[r] = ($urandom_range(1) != 0) ? 5'($urandom_range(3)) : 5'($urandom_range(31));
      end
      clr_req = ($urandom_range(59) == 0);
      step();
    end
    idle_inputs();
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
